dot5_mac_rx: RTL and testbench

//   Receiving end of the operand-pair stream that the stimulus benches drive into the neuron datapath.
//   - Accepts unsigned W-bit (a,b) pairs over a valid/ready handshake.
//   - Multiply-accumulates N consecutive pairs into one dot product.
//   - Presents the dot product on a held valid/ready output port.

---
 rtl/dot5_mac_rx_pkg.sv | 18 +
 rtl/dot5_mac_rx_uint_mult.sv | 12 +
 rtl/dot5_mac_rx.sv | 105 ++++++++++
 tb/tb_dot5_mac_rx.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/dot5_mac_rx_pkg.sv
// Shared definitions for the NN datapath receive stage: default operand
// geometry, accumulator width derivation and FSM state encodings.
package dot5_mac_rx_pkg;

  localparam int W_DEF = 5;
  localparam int N_DEF = 4;

  // Width that holds N full-width products without overflow.
  function automatic int acc_width(input int w, input int n);
    return 2 * w + $clog2(n);
  endfunction

  typedef enum logic {
    ST_COLLECT = 1'b0,
    ST_DONE    = 1'b1
  } state_e;

endpackage

// File: rtl/dot5_mac_rx_uint_mult.sv
// Unsigned W x W -> 2W combinational multiplier, shared by the neuron blocks.
module uint_mult #(
  parameter int W = 5
) (
  input  logic [W-1:0]   a_i,
  input  logic [W-1:0]   b_i,
  output logic [2*W-1:0] p_o
);

  assign p_o = (2 * W)'(a_i) * (2 * W)'(b_i);

endmodule

// File: rtl/dot5_mac_rx.sv
// Receives (a,b) operand pairs, multiply-accumulates N of them and presents
// the dot product on a held valid/ready output.
module dot5_mac_rx
  import dot5_mac_rx_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int N     = N_DEF,
  parameter int ACC_W = acc_width(W, N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data
);

  localparam int             CNT_W = $clog2(N);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(N - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic               out_valid_q, out_valid_d;
  logic [ACC_W-1:0]   out_data_q, out_data_d;
  logic [2*W-1:0]     product;
  logic [ACC_W-1:0]   sum;

  uint_mult #(.W(W)) u_mult (
    .a_i (in_a),
    .b_i (in_b),
    .p_o (product)
  );

  assign sum      = acc_q + ACC_W'(product);
  assign in_ready = (state_q == ST_COLLECT);

  always_comb begin
    // NOTE: every next-state signal gets its hold value first so no path
    // through the branches below can infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;

    // clear outranks both handshakes; a pair offered alongside it is dropped.
    if (clear) begin
      state_d     = ST_COLLECT;
      cnt_d       = '0;
      acc_d       = '0;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_COLLECT: begin
          if (in_valid) begin
            if (cnt_q == LAST) begin
              out_data_d  = sum;
              out_valid_d = 1'b1;
              cnt_d       = '0;
              acc_d       = '0;
              state_d     = ST_DONE;
            end else begin
              acc_d = sum;
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid_d = 1'b0;
            state_d     = ST_COLLECT;
          end
        end
        default: state_d = ST_COLLECT;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_COLLECT;
      cnt_q       <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_dot5_mac_rx.sv
// Directed bench for dot5_mac_rx: a vector table for the single-cycle
// behaviour plus hand-written reset sequences.
module tb_dot5_mac_rx;

  localparam int W     = 5;
  localparam int N     = 4;
  localparam int ACC_W = 12;

  logic             clk;
  logic             rst_n;
  logic             clear;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_a;
  logic [W-1:0]     in_b;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_data;

  int checks   = 0;
  int failures = 0;

  dot5_mac_rx #(.W(W), .N(N), .ACC_W(ACC_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string            tag;
    logic             clr;
    logic             iv;
    logic [W-1:0]     a;
    logic [W-1:0]     b;
    logic             ordy;
    logic             exp_ir;
    logic             exp_ov;
    logic             chk_data;
    logic [ACC_W-1:0] exp_data;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic add(input string tag, input logic clr, input logic iv,
                     input int a, input int b, input logic ordy,
                     input logic exp_ir, input logic exp_ov,
                     input logic chk_data, input int exp_data);
    vec_t v;
    v.tag      = tag;
    v.clr      = clr;
    v.iv       = iv;
    v.a        = W'(a);
    v.b        = W'(b);
    v.ordy     = ordy;
    v.exp_ir   = exp_ir;
    v.exp_ov   = exp_ov;
    v.chk_data = chk_data;
    v.exp_data = ACC_W'(exp_data);
    vecs.push_back(v);
  endtask

  task automatic drive(input logic clr, input logic iv, input int a, input int b, input logic ordy);
    clear     = clr;
    in_valid  = iv;
    in_a      = W'(a);
    in_b      = W'(b);
    out_ready = ordy;
  endtask

  // Apply one input set, take the edge, sample 1 time unit later.
  task automatic step(input logic clr, input logic iv, input int a, input int b, input logic ordy);
    drive(clr, iv, a, b, ordy);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 0, 0, 1'b0);

    // Each row: inputs for one cycle, then expected outputs just after that edge.
    // Basic: 2*20 + 1*0 + 15*28 + 3*3 = 469
    add("basic_p0", 0, 1,  2, 20, 1, 1, 0, 0, 0);
    add("basic_p1", 0, 1,  1,  0, 1, 1, 0, 0, 0);
    add("basic_p2", 0, 1, 15, 28, 1, 1, 0, 0, 0);
    add("basic_p3", 0, 1,  3,  3, 1, 0, 1, 1, 469);
    add("basic_ack", 0, 0, 0, 0, 1, 1, 0, 1, 469);
    // Max operands: 4 * 961 = 3844
    add("max_p0", 0, 1, 31, 31, 1, 1, 0, 0, 0);
    add("max_p1", 0, 1, 31, 31, 1, 1, 0, 0, 0);
    add("max_p2", 0, 1, 31, 31, 1, 1, 0, 0, 0);
    add("max_p3", 0, 1, 31, 31, 1, 0, 1, 1, 3844);
    add("max_ack", 0, 0, 0, 0, 1, 1, 0, 0, 0);
    // Backpressure: result held for 3 stalled cycles; offered pairs ignored in DONE
    add("bp_p0", 0, 1,  2, 20, 0, 1, 0, 0, 0);
    add("bp_p1", 0, 1,  1,  0, 0, 1, 0, 0, 0);
    add("bp_p2", 0, 1, 15, 28, 0, 1, 0, 0, 0);
    add("bp_p3", 0, 1,  3,  3, 0, 0, 1, 1, 469);
    add("bp_hold0", 0, 1, 9, 9, 0, 0, 1, 1, 469);
    add("bp_hold1", 0, 1, 9, 9, 0, 0, 1, 1, 469);
    add("bp_hold2", 0, 1, 9, 9, 0, 0, 1, 1, 469);
    add("bp_ack", 0, 1, 9, 9, 1, 1, 0, 1, 469);
    // Accepts right after the handshake: 1 + 2 + 4 + 3 = 10
    add("bp_next0", 0, 1, 1, 1, 0, 1, 0, 0, 0);
    add("bp_next1", 0, 1, 1, 2, 0, 1, 0, 0, 0);
    add("bp_next2", 0, 1, 2, 2, 0, 1, 0, 0, 0);
    add("bp_next3", 0, 1, 3, 1, 0, 0, 1, 1, 10);
    add("bp_next_ack", 0, 0, 0, 0, 1, 1, 0, 0, 0);
    // Gaps and clear: pre-clear pairs and (7,7) dropped, 1 + 4 + 9 + 16 = 30
    add("gap_p0", 0, 1, 5, 5, 1, 1, 0, 0, 0);
    add("gap_stall0", 0, 0, 30, 30, 1, 1, 0, 0, 0);
    add("gap_stall1", 0, 0, 30, 30, 1, 1, 0, 0, 0);
    add("gap_p1", 0, 1, 4, 4, 1, 1, 0, 0, 0);
    add("gap_clear", 1, 1, 7, 7, 1, 1, 0, 0, 0);
    add("gap_q0", 0, 1, 1, 1, 1, 1, 0, 0, 0);
    add("gap_q1", 0, 1, 2, 2, 1, 1, 0, 0, 0);
    add("gap_q2", 0, 1, 3, 3, 1, 1, 0, 0, 0);
    add("gap_q3", 0, 1, 4, 4, 1, 0, 1, 1, 30);
    // Clear in DONE drops the result even with out_ready=1 on that edge
    add("done_clear", 1, 0, 0, 0, 1, 1, 0, 0, 0);
    add("done_clear_idle", 0, 0, 0, 0, 1, 1, 0, 0, 0);
    add("post_clear0", 0, 1, 2, 1, 0, 1, 0, 0, 0);
    add("post_clear1", 0, 1, 2, 1, 0, 1, 0, 0, 0);
    add("post_clear2", 0, 1, 2, 1, 0, 1, 0, 0, 0);
    add("post_clear3", 0, 1, 2, 1, 0, 0, 1, 1, 8);
    add("post_clear_ack", 0, 0, 0, 0, 1, 1, 0, 0, 0);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_data", 32'(out_data), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd0 + 32'd1);
    rst_n = 1'b1;
    #1;
    check("post_reset_in_ready", 32'(in_ready), 32'd1);

    foreach (vecs[i]) begin
      step(vecs[i].clr, vecs[i].iv, int'(vecs[i].a), int'(vecs[i].b), vecs[i].ordy);
      check({vecs[i].tag, ".in_ready"}, 32'(in_ready), 32'(vecs[i].exp_ir));
      check({vecs[i].tag, ".out_valid"}, 32'(out_valid), 32'(vecs[i].exp_ov));
      if (vecs[i].chk_data)
        check({vecs[i].tag, ".out_data"}, 32'(out_data), 32'(vecs[i].exp_data));
    end

    // Reset mid-vector: partial sum of (9,9)(9,9) must be lost
    step(1'b0, 1'b1, 9, 9, 1'b1);
    step(1'b0, 1'b1, 9, 9, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int k = 0; k < N; k++) step(1'b0, 1'b1, 1, 1, 1'b0);
    check("midrst_out_valid_after", 32'(out_valid), 32'd1);
    check("midrst_out_data", 32'(out_data), 32'd4);

    // Reset while holding a result in DONE: out_valid drops without a clock edge
    step(1'b0, 1'b0, 0, 0, 1'b0);
    check("donerst_hold", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("donerst_out_valid", 32'(out_valid), 32'd0);
    check("donerst_out_data", 32'(out_data), 32'd0);
    check("donerst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    step(1'b0, 1'b0, 0, 0, 1'b1);
    check("donerst_idle_valid", 32'(out_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
